alu_sequencer: RTL and testbench
================================

# alu_sequencer

Command-driven controller for the 8-bit add/subtract unit: it owns the accumulator and B operand register, drives the adder's A/B inputs and su/eu controls, and captures the 8-bit result back from the adder output. It sits between the instruction-control logic, which issues one command at a time with an operand from the data bus, and the combinational add/subtract unit. Condition flags (zero, negative, carry/borrow) are updated for each executed command.

## Interface
Parameters:
- WIDTH, 8, data width of bus, operands, accumulator and result. Only 8 is verified.

Ports:
- clk  in  1  system clock, rising-edge.
- clr_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  sequencer can accept a command; high only in IDLE.
- cmd_op  in  2  00 ADD, 01 SUB, 10 LDA (load accumulator), 11 CMP (subtract, flags only).
- bus_in  in  WIDTH  operand, sampled with the accepted command.
- alu_a  out  WIDTH  adder A input; always equals acc.
- alu_b  out  WIDTH  adder B input; always equals breg.
- alu_su  out  1  0 add, 1 subtract.
- alu_eu  out  1  adder output enable; high only in EXEC.
- alu_s  in  WIDTH  adder result; valid only while alu_eu=1.
- acc  out  WIDTH  accumulator.
- flag_z, flag_n, flag_c  out  1 each  zero, negative, carry/borrow.
- done  out  1  one-cycle pulse when a command completes.
- err  out  1  sticky result-mismatch flag (ALU_CHECK_EN only; else tied 0).

## Operation
- States: IDLE, EXEC, DONE. Reset enters IDLE.
- Accept: cmd_valid & cmd_ready at a rising edge. On accept, breg <= bus_in, op latched.
- IDLE -> EXEC for ADD/SUB/CMP; IDLE -> DONE for LDA (acc <= bus_in at the accept edge).
- EXEC: alu_eu=1, alu_su=1 for SUB/CMP, 0 for ADD. At the EXEC->DONE edge: ADD/SUB acc <= alu_s; CMP leaves acc unchanged; flags updated.
- DONE: done=1 for exactly one cycle, then IDLE.
- Flags from result r (alu_s, or bus_in for LDA): flag_z = (r==0); flag_n = r[7].
- flag_c: ADD = bit 8 of the 9-bit {0,acc}+{0,breg}; SUB/CMP = 1 when acc < breg unsigned (borrow); LDA leaves flag_c unchanged.
- Arithmetic wraps modulo 2^WIDTH. The carry is computed locally; it is not taken from the adder.
- cmd_valid while cmd_ready=0 is ignored and is not queued. The requester holds the command until it is accepted.
- alu_su is 0 outside EXEC. alu_eu=0 keeps the adder output high-impedance.

## Timing
- Reset values: acc=0, breg=0, flag_z=0, flag_n=0, flag_c=0, done=0, err=0, alu_eu=0, alu_su=0, state IDLE. cmd_ready=1 once clr_n deasserts.
- Reset is asynchronous on assertion. An asserted clr_n mid-EXEC aborts the command: no writeback and no done.
- ADD/SUB/CMP: accept at edge 0, EXEC during cycle 1, writeback at edge 1, done high during cycle 2, cmd_ready high again in cycle 3. The next accept is possible at edge 3.
- LDA: accept at edge 0, acc visible after edge 0, done during cycle 1, next accept at edge 2.
- alu_a and alu_b are stable for the whole EXEC cycle. Add_Sub is combinational, so the result is sampled in the same cycle.

## Configuration
- ALU_CHECK_EN defined: at the EXEC->DONE edge the sequencer computes the expected result (acc±breg mod 2^WIDTH). A mismatch against alu_s sets err=1. err is sticky until clr_n. Writeback still uses alu_s.
- ALU_CHECK_EN undefined: err is tied to 0 and no compare logic is built.

## Test plan
- LDA 0x05, then ADD 0x03 -> acc=0x08, z=0 n=0 c=0. done appears 2 cycles after the ADD accept; cmd_ready is low for cycles 1-2.
- With acc=0x08, ADD 0xFF -> acc=0x07, c=1. Then SUB 0x08 -> acc=0xFF, n=1, c=1 (borrow), z=0.
- LDA 0x3C, then CMP 0x3C -> acc stays 0x3C, z=1, c=0. CMP 0x40 -> c=1, n=1, acc 0x3C.
- Hold cmd_valid with op ADD through EXEC/DONE -> exactly one command executes per accept. alu_eu is high for exactly one cycle per ADD/SUB/CMP and never during LDA or IDLE.
- Assert clr_n low during EXEC of SUB -> all outputs return to reset values immediately, and no done pulse follows.
- ALU_CHECK_EN: the bench drives alu_s=0x00 for ADD 0x01 onto 0x01 -> err=1 after writeback and stays 1 through later correct commands until reset. Without the macro, err stays 0.

Source files
------------

// File: rtl/alu_sequencer.sv
// alu_sequencer: owns acc/breg, steps the external combinational add/subtract unit, updates z/n/c flags.
// Latency: ADD/SUB/CMP done pulses 2 cycles after accept, LDA 1 cycle; next accept one cycle after done.
// Backpressure: cmd_ready high only in IDLE; commands offered while busy are ignored, not queued.
// Optional build: define ALU_CHECK_EN to add the expected-result compare that drives the sticky err flag.
module alu_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] bus_in,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_su,
  output logic             alu_eu,
  input  logic [WIDTH-1:0] alu_s,
  output logic [WIDTH-1:0] acc,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_c,
  output logic             done,
  output logic             err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_LDA = 2'b10;
  localparam logic [1:0] OP_CMP = 2'b11;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] breg_q, breg_d;
  logic [1:0]       op_q, op_d;
  logic             z_q, z_d;
  logic             n_q, n_d;
  logic             c_q, c_d;

  logic             accept;
  logic             add_carry;
  logic             sub_borrow;

  assign accept = cmd_valid && (state_q == ST_IDLE);

  // acc + breg overflows exactly when acc exceeds (2^WIDTH-1) - breg, i.e. ~breg;
  // the carry is derived locally so a faulty adder cannot corrupt it.
  assign add_carry  = (acc_q > ~breg_q);
  assign sub_borrow = (acc_q < breg_q);

  // State and datapath registers; reset aborts any command in flight.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      breg_q  <= '0;
      op_q    <= OP_ADD;
      z_q     <= 1'b0;
      n_q     <= 1'b0;
      c_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      breg_q  <= breg_d;
      op_q    <= op_d;
      z_q     <= z_d;
      n_q     <= n_d;
      c_q     <= c_d;
    end
  end

  // Next-state, operand capture, writeback and flag update.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    breg_d  = breg_q;
    op_d    = op_q;
    z_d     = z_q;
    n_d     = n_q;
    c_d     = c_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          breg_d = bus_in;
          op_d   = cmd_op;
          if (cmd_op == OP_LDA) begin
            // LDA completes at the accept edge; carry is left untouched.
            acc_d   = bus_in;
            z_d     = (bus_in == '0);
            n_d     = bus_in[WIDTH-1];
            state_d = ST_DONE;
          end else begin
            state_d = ST_EXEC;
          end
        end
      end
      ST_EXEC: begin
        if (op_q != OP_CMP) begin
          acc_d = alu_s;
        end
        z_d     = (alu_s == '0);
        n_d     = alu_s[WIDTH-1];
        c_d     = (op_q == OP_ADD) ? add_carry : sub_borrow;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // EXEC is only entered for ADD/SUB/CMP, so anything but ADD subtracts.
  assign alu_eu    = (state_q == ST_EXEC);
  assign alu_su    = (state_q == ST_EXEC) && (op_q != OP_ADD);
  assign alu_a     = acc_q;
  assign alu_b     = breg_q;
  assign cmd_ready = (state_q == ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign acc       = acc_q;
  assign flag_z    = z_q;
  assign flag_n    = n_q;
  assign flag_c    = c_q;

`ifdef ALU_CHECK_EN
  logic             err_q;
  logic [WIDTH-1:0] expect_r;

  assign expect_r = (op_q == OP_ADD) ? (acc_q + breg_q) : (acc_q - breg_q);

  // Sticky mismatch between the adder output and the locally predicted result.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      err_q <= 1'b0;
    end else if ((state_q == ST_EXEC) && (alu_s != expect_r)) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: directed table, held-valid, reset-abort and random commands.
// The external add/subtract unit is modelled here; expected results come from a plain arithmetic model.
module tb_alu_sequencer;

  logic       clk;
  logic       clr_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] bus_in;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic       alu_su;
  logic       alu_eu;
  logic [7:0] alu_s;
  logic [7:0] acc;
  logic       flag_z;
  logic       flag_n;
  logic       flag_c;
  logic       done;
  logic       err;
  logic       bad_adder;

  int n_checks = 0;
  int n_pass   = 0;

  int m_acc = 0;
  int m_z   = 0;
  int m_n   = 0;
  int m_c   = 0;

  alu_sequencer #(.WIDTH(8)) dut (
    .clk(clk), .clr_n(clr_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .bus_in(bus_in), .alu_a(alu_a), .alu_b(alu_b),
    .alu_su(alu_su), .alu_eu(alu_eu), .alu_s(alu_s), .acc(acc),
    .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural add/subtract unit; bad_adder forces a wrong (zero) result.
  always_comb begin
    alu_s = 8'h00;
    if (alu_eu && !bad_adder) alu_s = alu_su ? (alu_a - alu_b) : (alu_a + alu_b);
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // Reference model: ops 0 ADD, 1 SUB, 2 LDA, 3 CMP.
  task automatic model_cmd(input int op, input int v);
    int r;
    r = 0;
    case (op)
      0: begin r = m_acc + v; m_c = (r > 255) ? 1 : 0; r = r % 256; m_acc = r; end
      1: begin r = m_acc - v; m_c = (r < 0) ? 1 : 0; if (r < 0) r += 256; m_acc = r; end
      2: begin r = v; m_acc = v; end
      default: begin r = m_acc - v; m_c = (r < 0) ? 1 : 0; if (r < 0) r += 256; end
    endcase
    m_z = (r == 0) ? 1 : 0;
    m_n = (r >= 128) ? 1 : 0;
  endtask

  // Issue one command at a negedge, then sample each following cycle until done.
  task automatic run_cmd(input logic [1:0] op, input logic [7:0] v,
                         output int lat, output int eu_cnt, output int rdy_hi);
    int n;
    n = 0;
    while (!cmd_ready && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) check("ready_timeout", 0, 1);
    cmd_valid = 1'b1; cmd_op = op; bus_in = v;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    lat = 0; eu_cnt = 0; rdy_hi = 0;
    while (lat < 10) begin
      @(negedge clk);
      lat++;
      if (alu_eu) eu_cnt++;
      if (cmd_ready) rdy_hi++;
      if (done) break;
    end
  endtask

  typedef struct {
    logic [1:0] op;
    logic [7:0] v;
    logic [7:0] e_acc;
    logic [2:0] e_znc;
    int         e_lat;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int lat, eu, rdy, dn, ecnt;
    vecs[0] = '{2'b10, 8'h05, 8'h05, 3'b000, 1};
    vecs[1] = '{2'b00, 8'h03, 8'h08, 3'b000, 2};
    vecs[2] = '{2'b00, 8'hFF, 8'h07, 3'b001, 2};
    vecs[3] = '{2'b01, 8'h08, 8'hFF, 3'b011, 2};
    vecs[4] = '{2'b10, 8'h3C, 8'h3C, 3'b001, 1};
    vecs[5] = '{2'b11, 8'h3C, 8'h3C, 3'b100, 2};
    vecs[6] = '{2'b11, 8'h40, 8'h3C, 3'b011, 2};
    vecs[7] = '{2'b10, 8'h80, 8'h80, 3'b011, 1};
    vecs[8] = '{2'b00, 8'h80, 8'h00, 3'b101, 2};
    vecs[9] = '{2'b01, 8'h01, 8'hFF, 3'b011, 2};

    clr_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; bus_in = 8'h00; bad_adder = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_acc", acc, 8'h00);
    check("rst_flags", {flag_z, flag_n, flag_c}, 3'b000);
    check("rst_done_eu_su", {done, alu_eu, alu_su}, 3'b000);
    check("rst_err", err, 1'b0);
    check("rst_alu_b", alu_b, 8'h00);
    clr_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst", cmd_ready, 1'b1);

    // Directed table from the command-level test plan.
    for (int i = 0; i < 10; i++) begin
      run_cmd(vecs[i].op, vecs[i].v, lat, eu, rdy);
      model_cmd(int'(vecs[i].op), int'(vecs[i].v));
      check($sformatf("vec%0d_acc", i), acc, vecs[i].e_acc);
      check($sformatf("vec%0d_znc", i), {flag_z, flag_n, flag_c}, vecs[i].e_znc);
      check($sformatf("vec%0d_latency", i), lat, vecs[i].e_lat);
      check($sformatf("vec%0d_eu_cycles", i), eu, (vecs[i].op == 2'b10) ? 0 : 1);
      check($sformatf("vec%0d_ready_low", i), rdy, 0);
    end

    // Hold an ADD request through nine edges: accepts land at edges 0, 3 and 6 only.
    while (!cmd_ready) @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'b00; bus_in = 8'h01;
    dn = 0; ecnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (i == 8) cmd_valid = 1'b0;
      if (done) dn++;
      if (alu_eu) ecnt++;
    end
    repeat (3) model_cmd(0, 1);
    check("hold_done_pulses", dn, 3);
    check("hold_eu_cycles", ecnt, 3);
    check("hold_acc", acc, m_acc[7:0]);

    // Reset during EXEC of a SUB aborts it.
    run_cmd(2'b10, 8'h30, lat, eu, rdy);
    model_cmd(2, 8'h30);
    while (!cmd_ready) @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'b01; bus_in = 8'h10;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    check("abort_exec_eu_su", {alu_eu, alu_su}, 2'b11);
    #2 clr_n = 1'b0;
    #1;
    check("abort_acc", acc, 8'h00);
    check("abort_flags", {flag_z, flag_n, flag_c}, 3'b000);
    check("abort_ctrl", {done, alu_eu, alu_su, err}, 4'b0000);
    @(negedge clk);
    clr_n = 1'b1;
    dn = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done) dn++;
    end
    check("abort_no_done", dn, 0);
    check("abort_ready", cmd_ready, 1'b1);
    m_acc = 0; m_z = 0; m_n = 0; m_c = 0;

    // Random commands against the reference model.
    for (int i = 0; i < 40; i++) begin
      int op, v;
      op = int'($urandom_range(0, 3));
      v  = int'($urandom_range(0, 255));
      run_cmd(op[1:0], v[7:0], lat, eu, rdy);
      model_cmd(op, v);
      check($sformatf("rnd%0d_acc", i), acc, m_acc[7:0]);
      check($sformatf("rnd%0d_znc", i), {flag_z, flag_n, flag_c},
            {m_z[0], m_n[0], m_c[0]});
      check($sformatf("rnd%0d_latency", i), lat, (op == 2) ? 1 : 2);
    end

`ifdef ALU_CHECK_EN
    run_cmd(2'b10, 8'h01, lat, eu, rdy);
    bad_adder = 1'b1;
    run_cmd(2'b00, 8'h01, lat, eu, rdy);
    bad_adder = 1'b0;
    check("err_set", err, 1'b1);
    check("err_writeback_uses_alu_s", acc, 8'h00);
    m_acc = 0; m_z = 1; m_n = 0; m_c = 0;
    run_cmd(2'b00, 8'h02, lat, eu, rdy);
    model_cmd(0, 2);
    check("err_sticky", err, 1'b1);
    check("err_after_acc", acc, m_acc[7:0]);
    clr_n = 1'b0;
    #1 check("err_cleared_by_reset", err, 1'b0);
    @(negedge clk);
    clr_n = 1'b1;
`else
    check("err_tied_low", err, 1'b0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
